// File: rtl/mult_control_unit.sv
// Sequencing controller for the shift-add signed multiplier datapath.
// Optional single-step mode is enabled by defining MULT_CTRL_STEP_EN.
module mult_control_unit #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
`ifdef MULT_CTRL_STEP_EN
    input  logic Step,
`endif
    output logic Clr_Ld,
    output logic ClearXA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    typedef enum logic [2:0] {
        IDLE,
        CLRXA,
        ADD,
        SHIFT,
        HOLD
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] k, k_next;
    logic             adv;
    logic             last;

`ifdef MULT_CTRL_STEP_EN
    assign adv = Step;
`else
    assign adv = 1'b1;
`endif

    assign last = (k == CNT_W'(N_BITS - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    // Outputs are forced low while Reset is high, even before state settles.
    always_comb begin
        state_next = state;
        k_next     = k;
        Clr_Ld     = 1'b0;
        ClearXA    = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Shift      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        state_next = CLRXA;
                        k_next     = '0;
                    end else if (ClearA_LoadB) begin
                        Clr_Ld = 1'b1;
                    end
                end
                CLRXA: begin
                    Busy    = 1'b1;
                    ClearXA = adv;
                    if (adv) state_next = ADD;
                end
                ADD: begin
                    Busy = 1'b1;
                    Add  = adv & M & ~last;
                    Sub  = adv & M & last;
                    if (adv) state_next = SHIFT;
                end
                SHIFT: begin
                    Busy  = 1'b1;
                    Shift = adv;
                    // Exit is tested before incrementing so k never wraps.
                    if (adv) begin
                        if (last) begin
                            state_next = HOLD;
                        end else begin
                            k_next     = k + 1'b1;
                            state_next = ADD;
                        end
                    end
                end
                HOLD: begin
                    Done = 1'b1;
                    if (!Run) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
